// File: rtl/clock_pkg.sv
// Shared field indices, edit-state encoding and decode helpers for the
// time/date setting logic.
package clock_pkg;

  localparam int FLD_SEC    = 0;
  localparam int FLD_MIN    = 1;
  localparam int FLD_HOUR   = 2;
  localparam int FLD_DAY    = 3;
  localparam int FLD_MONTH  = 4;
  localparam int FLD_YEAR   = 5;
  localparam int NUM_FIELDS = 6;

  typedef enum logic [2:0] {
    RUN,
    SET_SEC,
    SET_MIN,
    SET_HOUR,
    SET_DAY,
    SET_MONTH,
    SET_YEAR
  } set_state_t;

  function automatic logic [NUM_FIELDS-1:0] field_onehot(input set_state_t s);
    logic [NUM_FIELDS-1:0] oh;
    oh = '0;
    case (s)
      SET_SEC:   oh[FLD_SEC]   = 1'b1;
      SET_MIN:   oh[FLD_MIN]   = 1'b1;
      SET_HOUR:  oh[FLD_HOUR]  = 1'b1;
      SET_DAY:   oh[FLD_DAY]   = 1'b1;
      SET_MONTH: oh[FLD_MONTH] = 1'b1;
      SET_YEAR:  oh[FLD_YEAR]  = 1'b1;
      default:   oh = '0;
    endcase
    return oh;
  endfunction

  function automatic set_state_t next_field(input set_state_t s);
    set_state_t n;
    case (s)
      RUN:       n = SET_SEC;
      SET_SEC:   n = SET_MIN;
      SET_MIN:   n = SET_HOUR;
      SET_HOUR:  n = SET_DAY;
      SET_DAY:   n = SET_MONTH;
      SET_MONTH: n = SET_YEAR;
      default:   n = RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/time_set_controller_btn_repeat.sv
// Rising-edge detect plus hold-to-repeat for one up/down button; fire is a
// combinational request that the top module registers into a pulse.
module btn_repeat #(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic enable,
  input  logic fast_tick,
  output logic fire
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  logic          btn_prev_q, btn_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rpt_q, rpt_d;
  logic          rise;

  // An edge wins over a coincident fast_tick: it fires and restarts the count.
  always_comb begin
    btn_prev_d = btn;
    cnt_d      = cnt_q;
    rpt_d      = rpt_q;
    fire       = 1'b0;
    rise       = btn & ~btn_prev_q;
    if (!enable || !btn) begin
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (rise) begin
      fire  = 1'b1;
      cnt_d = '0;
      rpt_d = 1'b0;
    end else if (fast_tick) begin
      if (!rpt_q) begin
        if (cnt_q == DELAY_LAST) begin
          fire  = 1'b1;
          rpt_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q == RATE_LAST) begin
        fire  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      cnt_q      <= '0;
      rpt_q      <= 1'b0;
    end else begin
      btn_prev_q <= btn_prev_d;
      cnt_q      <= cnt_d;
      rpt_q      <= rpt_d;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Manual time/date setting sequencer: mode stepping, up/down pulse generation
// with auto-repeat, inactivity timeout and field blink.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2,
  parameter int TIMEOUT_S    = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_mode,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  fast_tick,
  input  logic                  sec_tick,
  input  logic                  blink_tick,
  output logic [NUM_FIELDS-1:0] manual_set,
  output logic                  up,
  output logic                  down,
  output logic                  editing,
  output logic                  blink
);

  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_S);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

  set_state_t            state_q, state_d;
  logic [NUM_FIELDS-1:0] manual_set_q, manual_set_d;
  logic                  editing_q, editing_d;
  logic                  up_q, up_d, down_q, down_d;
  logic                  blink_q, blink_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  mode_prev_q, up_prev_q, down_prev_q;
  logic                  mode_rise, any_rise, in_edit, state_chg;
  logic                  both_pressed, rpt_enable, fire_up, fire_down;

  assign in_edit      = (state_q != RUN);
  assign both_pressed = btn_up & btn_down;
  assign rpt_enable   = editing_q & ~both_pressed;

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_up (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn_up),
    .enable    (rpt_enable),
    .fast_tick (fast_tick),
    .fire      (fire_up)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_down (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn_down),
    .enable    (rpt_enable),
    .fast_tick (fast_tick),
    .fire      (fire_down)
  );

  // A button edge restarts the timeout, so it also blocks a coincident expiry.
  always_comb begin
    mode_rise = btn_mode & ~mode_prev_q;
    any_rise  = mode_rise | (btn_up & ~up_prev_q) | (btn_down & ~down_prev_q);

    state_d = state_q;
    if (mode_rise) begin
      state_d = next_field(state_q);
    end else if (in_edit && !any_rise &&
                 ((to_cnt_q == TO_MAX) || (sec_tick && to_cnt_q == TO_LAST))) begin
      state_d = RUN;
    end
    state_chg = (state_d != state_q);

    to_cnt_d = to_cnt_q;
    if (any_rise || state_chg) begin
      to_cnt_d = '0;
    end else if (in_edit && sec_tick && to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    blink_d = blink_q;
    if (state_chg || state_d == RUN) begin
      blink_d = 1'b0;
    end else if (blink_tick) begin
      blink_d = ~blink_q;
    end

    // Pulses never coincide with a change of the selected field.
    up_d   = fire_up & ~fire_down & in_edit & ~state_chg;
    down_d = fire_down & ~fire_up & in_edit & ~state_chg;

    manual_set_d = field_onehot(state_d);
    editing_d    = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      manual_set_q <= '0;
      editing_q    <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      blink_q      <= 1'b0;
      to_cnt_q     <= '0;
      mode_prev_q  <= 1'b0;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      manual_set_q <= manual_set_d;
      editing_q    <= editing_d;
      up_q         <= up_d;
      down_q       <= down_d;
      blink_q      <= blink_d;
      to_cnt_q     <= to_cnt_d;
      mode_prev_q  <= btn_mode;
      up_prev_q    <= btn_up;
      down_prev_q  <= btn_down;
    end
  end

  assign manual_set = manual_set_q;
  assign editing    = editing_q;
  assign up         = up_q;
  assign down       = down_q;
  assign blink      = blink_q;

endmodule
